dac_spi_out: RTL
================

// Module: dac_spi_out
// PURPOSE
//  Downstream stage of top_vector_display: takes each (x_ch, y_ch) beam position and writes it to a
//  dual-channel 12-bit SPI DAC (MCP4822-class) as two 16-bit frames, X then Y.
//  A single LDAC pulse follows both frames, so both analog outputs update together.
//  Provides valid/ready back-pressure so the vector engine cannot outrun the DAC.
// PARAMETERS
//  DAC_WIDTH  8   width of x_in/y_in (vector_pkg::DAC_WIDTH); must be <= DAC_BITS
//  DAC_BITS   12  DAC resolution; input is left-aligned, LSBs zero-padded
//  CLK_DIV    4   clk cycles per SCLK half-period (>=1)
//  CS_GAP     2   clk cycles cs_n held high between/after frames (>=1)
// PORTS
//  clk       in   1          system clock
//  rst       in   1          synchronous, active-high reset
//  x_in      in   DAC_WIDTH  X sample, channel A
//  y_in      in   DAC_WIDTH  Y sample, channel B
//  valid_in  in   1          sample pair valid
//  ready_out out  1          accepting; transfer when valid_in & ready_out at posedge clk
//  sclk      out  1          SPI clock, idles low, DAC samples on rising edge
//  mosi      out  1          SPI data, MSB first, changes only while sclk low
//  cs_n      out  1          chip select, active low
//  ldac_n    out  1          latch strobe, active low
//  busy      out  1          high from acceptance until return to IDLE
// BEHAVIOUR
//  Reset: sclk=0, mosi=0, cs_n=1, ldac_n=1, busy=0, ready_out=0 while rst high; FSM -> IDLE.
//  Reset mid-transfer aborts immediately; no LDAC pulse is issued and the sample is dropped.
//  ready_out = (state==IDLE) & ~rst. x_in/y_in are latched on acceptance and ignored afterwards.
//  Frame = {ch, 1'b0 (unbuf), 1'b1 (gain 1x), 1'b1 (active), data[11:0]}; ch=0 for X, 1 for Y.
//  data = {sample, (DAC_BITS-DAC_WIDTH)'0}, e.g. x_in=8'hA5 -> 16'h3A50.
//  FSM: IDLE -> LOAD_X -> SHIFT -> GAP -> LOAD_Y -> SHIFT -> GAP -> LDAC -> IDLE.
//   LOAD (1 cycle): cs_n falls, mosi = frame[15], sclk = 0.
//   SHIFT (32*CLK_DIV cycles): 16 bits, each bit = CLK_DIV cycles low then CLK_DIV cycles high.
//    mosi advances at each sclk falling edge. After bit 0 high phase, sclk = 0.
//   GAP (CS_GAP cycles): cs_n = 1, mosi = 0.
//   LDAC (2*CLK_DIV cycles): ldac_n = 0, then returns to 1 on entry to IDLE.
//  Latency: ready_out is high again T = 2*(1+32*CLK_DIV+CS_GAP)+2*CLK_DIV cycles after the
//   acceptance edge (270 at defaults). Back-to-back valid gives one sample per T+1 cycles.
//  sclk never toggles while cs_n=1. Exactly 16 rising edges occur per cs_n low window.
//  valid_in during busy is ignored, not queued. The upstream holds its data until ready_out.
// CONFIGURATION
//  DAC_INVERT_Y_EN defined: Y data field = ~sample before padding, for a flipped CRT deflection.
//   Example: y_in=8'h00 -> 16'hBFF0 (pad bits stay 0).
//  Not defined: Y is sent unmodified, e.g. y_in=8'h00 -> 16'hB000. X is never inverted.
// STRUCTURE
//  vector_pkg: DAC_BITS, SPI_FRAME_W=16, config-bit localparams (CH/BUF/GA/SHDN positions),
//   typedef enum dac_state_t {IDLE,LOAD_X,LOAD_Y,SHIFT,GAP,LDAC}.
//  Sub-module spi_frame_tx: one 16-bit frame shifter with CLK_DIV divider and bit counter.
//   Interface: start/frame in, done pulse out. dac_spi_out owns the FSM, channel select and LDAC.
// TESTING
//  1 Reset then idle 50 cycles -> cs_n=1, ldac_n=1, sclk=0, ready_out=1 from cycle after rst low.
//  2 x=8'hA5, y=8'h3C single pulse -> SPI model decodes 16'h3A50 then 16'hB3C0, one ldac_n low
//    of 8 cycles, ready_out high again at +270.
//  3 valid held high with incrementing samples -> every pair delivered in order,
//    acceptances spaced 271 cycles, no frame overlap.
//  4 rst asserted at bit 7 of the Y frame -> next cycle cs_n=1, sclk=0, no ldac_n pulse,
//    next accepted pair is sent correctly.
//  5 CLK_DIV=1, CS_GAP=1 -> sclk period 2 cycles, still 16 edges/frame, T=70.
//  6 Compile with DAC_INVERT_Y_EN, y=8'h00 -> Y frame 16'hBFF0. Without it -> 16'hB000.
//  Assertions: mosi is stable while sclk=1; sclk=0 whenever cs_n=1; ldac_n=0 only while cs_n=1.

Source files
------------

// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared DAC constants, MCP4822 frame layout and the dac_spi_out state type
package vector_pkg;

  localparam int DAC_BITS    = 12;
  localparam int SPI_FRAME_W = 16;

  localparam int CH_BIT   = 15;
  localparam int BUF_BIT  = 14;
  localparam int GA_BIT   = 13;
  localparam int SHDN_BIT = 12;

  typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, SHIFT, GAP, LDAC} dac_state_t;

  // Unbuffered reference, 1x gain, output active; data occupies the low DAC_BITS bits.
  function automatic logic [SPI_FRAME_W-1:0] dac_frame(input logic ch,
                                                       input logic [DAC_BITS-1:0] data);
    logic [SPI_FRAME_W-1:0] f;
    f           = '0;
    f[CH_BIT]   = ch;
    f[BUF_BIT]  = 1'b0;
    f[GA_BIT]   = 1'b1;
    f[SHDN_BIT] = 1'b1;
    f[DAC_BITS-1:0] = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// rtl/spi_frame_tx.sv - shifts one 16-bit frame MSB first, CLK_DIV clk cycles per sclk half-period
module spi_frame_tx
  import vector_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SPI_FRAME_W-1:0] frame,
  output logic                   sclk,
  output logic                   mosi,
  output logic                   done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(SPI_FRAME_W);

  logic [CW-1:0]          div_cnt;
  logic                   phase;
  logic [BW-1:0]          bit_cnt;
  logic                   active;
  logic [SPI_FRAME_W-1:0] shreg;
  logic                   div_end;

  assign div_end = (div_cnt == CW'(CLK_DIV - 1));
  assign done    = active & phase & div_end & (bit_cnt == BW'(SPI_FRAME_W - 1));
  assign sclk    = active & phase;
  assign mosi    = shreg[SPI_FRAME_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      active  <= 1'b0;
      shreg   <= '0;
    end else if (start) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      active  <= 1'b1;
      shreg   <= frame;
    end else if (active) begin
      if (div_end) begin
        div_cnt <= '0;
        phase   <= ~phase;
        // End of a high phase is the sclk falling edge: advance to the next bit there.
        if (phase) begin
          shreg   <= {shreg[SPI_FRAME_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BW'(SPI_FRAME_W - 1)) active <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_spi_out.sv
// rtl/dac_spi_out.sv - writes each (x, y) pair to a dual 12-bit SPI DAC, X then Y, then one LDAC pulse
// Build option: define DAC_INVERT_Y_EN to send the Y sample bit-inverted.
module dac_spi_out
  import vector_pkg::*;
#(
  parameter int DAC_WIDTH = 8,
  parameter int DAC_BITS  = 12,
  parameter int CLK_DIV   = 4,
  parameter int CS_GAP    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DAC_WIDTH-1:0] x_in,
  input  logic [DAC_WIDTH-1:0] y_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 cs_n,
  output logic                 ldac_n,
  output logic                 busy
);

  dac_state_t             state, next;
  logic [15:0]            cnt;
  logic                   ch_y;
  logic [DAC_WIDTH-1:0]   x_lat, y_lat, y_samp;
  logic [DAC_BITS-1:0]    x_word, y_word;
  logic [SPI_FRAME_W-1:0] x_frame, y_frame, tx_frame;
  logic                   tx_start, tx_sclk, tx_mosi, tx_done;

`ifdef DAC_INVERT_Y_EN
  assign y_samp = ~y_lat;
`else
  assign y_samp = y_lat;
`endif

  // Samples are left-aligned in the DAC word; pad bits are always zero.
  assign x_word   = DAC_BITS'(x_lat) << (DAC_BITS - DAC_WIDTH);
  assign y_word   = DAC_BITS'(y_samp) << (DAC_BITS - DAC_WIDTH);
  assign x_frame  = dac_frame(1'b0, x_word);
  assign y_frame  = dac_frame(1'b1, y_word);
  assign tx_frame = (state == LOAD_Y) ? y_frame : x_frame;
  assign tx_start = (state == LOAD_X) || (state == LOAD_Y);

  spi_frame_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (tx_start),
    .frame (tx_frame),
    .sclk  (tx_sclk),
    .mosi  (tx_mosi),
    .done  (tx_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ch_y  <= 1'b0;
      x_lat <= '0;
      y_lat <= '0;
    end else begin
      state <= next;
      cnt   <= (next != state) ? '0 : cnt + 16'd1;
      if (state == IDLE && valid_in) begin
        x_lat <= x_in;
        y_lat <= y_in;
      end
      if (state == LOAD_X)      ch_y <= 1'b0;
      else if (state == LOAD_Y) ch_y <= 1'b1;
    end
  end

  always_comb begin
    next      = state;
    cs_n      = 1'b1;
    ldac_n    = 1'b1;
    sclk      = 1'b0;
    mosi      = 1'b0;
    busy      = (state != IDLE);
    ready_out = (state == IDLE);
    case (state)
      IDLE:   if (valid_in) next = LOAD_X;
      LOAD_X, LOAD_Y: begin
        next = SHIFT;
        cs_n = 1'b0;
        mosi = tx_frame[SPI_FRAME_W-1];
      end
      SHIFT: begin
        if (tx_done) next = GAP;
        cs_n = 1'b0;
        sclk = tx_sclk;
        mosi = tx_mosi;
      end
      GAP:    if (cnt == 16'(CS_GAP - 1)) next = ch_y ? LDAC : LOAD_Y;
      LDAC: begin
        if (cnt == 16'(2 * CLK_DIV - 1)) next = IDLE;
        ldac_n = 1'b0;
      end
      default: next = IDLE;
    endcase
    // Reset aborts at once: the bus is released and no LDAC pulse escapes.
    if (rst) begin
      cs_n      = 1'b1;
      ldac_n    = 1'b1;
      sclk      = 1'b0;
      mosi      = 1'b0;
      busy      = 1'b0;
      ready_out = 1'b0;
    end
  end

endmodule
